// File: rtl/decode_if.sv
// Fetch-to-decode-to-execute bundle: instruction handshake inputs plus registered control fields.
interface decode_if;
   logic       instr_valid_i;
   logic [7:0] instr_i;
   logic       ready_o;
   logic       cb_i;
   logic       stall_i;
   logic       valid_o;
   logic [3:0] alucontrol_o;
   logic [2:0] rs_addr_o;
   logic [2:0] rt_addr_o;
   logic [2:0] write_addr_o;
   logic [4:0] immediate_o;
   logic       regwrite_o;
   logic       CBwrite_o;
   logic       memread_o;
   logic       memwrite_o;
   logic       write_data_control_o;
   logic       branchf_o;
   logic       branchb_o;
   logic       done_o;

   modport master (
      output instr_valid_i, instr_i, cb_i, stall_i,
      input  ready_o, valid_o, alucontrol_o, rs_addr_o, rt_addr_o, write_addr_o,
             immediate_o, regwrite_o, CBwrite_o, memread_o, memwrite_o,
             write_data_control_o, branchf_o, branchb_o, done_o
   );

   modport slave (
      input  instr_valid_i, instr_i, cb_i, stall_i,
      output ready_o, valid_o, alucontrol_o, rs_addr_o, rt_addr_o, write_addr_o,
             immediate_o, regwrite_o, CBwrite_o, memread_o, memwrite_o,
             write_data_control_o, branchf_o, branchb_o, done_o
   );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decoder with valid/ready flow control, taken-branch squash
// window and a sticky halt state.
module decode_stage #(
   parameter int unsigned FLUSH_SLOTS = 1,
   parameter logic [2:0]  ACC_ADDR    = 3'd7,
   parameter logic [2:0]  SUBS_RS     = 3'd2,
   parameter logic [2:0]  SUBS_RT     = 3'd5,
   parameter logic [2:0]  SLT_RS      = 3'd6,
   parameter bit          DONE_LEVEL  = 1'b1
) (
   input logic     clk,
   input logic     reset,
   decode_if.slave bus
);
   typedef enum logic [1:0] {RUN, SQUASH, HALTED} state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] alu;
      logic [2:0] rs;
      logic [2:0] rt;
      logic [2:0] wa;
      logic [4:0] imm;
      logic       regwrite;
      logic       cbwrite;
      logic       memread;
      logic       memwrite;
      logic       wdc;
      logic       branchf;
      logic       branchb;
   } ctl_t;

   state_t     state_q, state_d;
   ctl_t       ctl_q, ctl_d, dec;
   logic [2:0] cnt_q, cnt_d;
   logic       done_q, done_d;
   logic       is_halt, is_taken, ready, accept;
   logic [2:0] lo;

   assign lo = bus.instr_i[2:0];

   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      is_halt   = 1'b0;
      is_taken  = 1'b0;
      casez (bus.instr_i[7:3])
         5'b00???: begin dec.alu = 4'b0000; dec.wa = bus.instr_i[5:3]; dec.rs = lo; dec.rt = ACC_ADDR; dec.regwrite = 1'b1; end
         5'b01???: begin dec.alu = 4'b0001; dec.wa = bus.instr_i[5:3]; dec.rs = lo; dec.rt = ACC_ADDR; dec.regwrite = 1'b1; end
         5'b110??: begin dec.alu = 4'b1000; dec.imm = bus.instr_i[4:0]; dec.wa = ACC_ADDR; dec.regwrite = 1'b1; end
         5'b11100: begin dec.alu = 4'b0010; dec.wa = lo; dec.rs = lo; dec.rt = ACC_ADDR; dec.regwrite = 1'b1; end
         5'b11101: begin dec.alu = 4'b0011; dec.wa = lo; dec.rs = lo; dec.rt = ACC_ADDR; dec.regwrite = 1'b1; end
         5'b10100: begin dec.alu = 4'b0110; dec.wa = lo; dec.rs = lo; dec.rt = ACC_ADDR; dec.regwrite = 1'b1; end
         5'b11111: begin dec.alu = 4'b0100; dec.rs = SUBS_RS; dec.rt = SUBS_RT; dec.wa = lo; dec.regwrite = 1'b1; end
         5'b10000: begin dec.alu = 4'b0101; dec.rs = SLT_RS; dec.rt = ACC_ADDR; dec.cbwrite = 1'b1; end
         5'b10101: begin dec.alu = 4'b0111; dec.rs = lo; dec.rt = ACC_ADDR; dec.cbwrite = 1'b1; end
         5'b10010: begin
            dec.alu = 4'b0001; dec.wa = lo; dec.rt = ACC_ADDR;
            dec.memread = 1'b1; dec.wdc = 1'b1; dec.regwrite = 1'b1;
         end
         5'b10011: begin dec.alu = 4'b0001; dec.rs = lo; dec.rt = ACC_ADDR; dec.memwrite = 1'b1; end
         5'b10111: begin dec.alu = 4'b1001; dec.rs = lo; dec.rt = ACC_ADDR; dec.wa = ACC_ADDR; dec.regwrite = 1'b1; end
         5'b11110: begin dec.alu = 4'b0001; dec.rs = lo; dec.branchf = bus.cb_i; is_taken = bus.cb_i; end
         5'b10110: begin dec.alu = 4'b0001; dec.rs = lo; dec.branchb = bus.cb_i; is_taken = bus.cb_i; end
         5'b10001: begin dec.alu = 4'b0001; is_halt = 1'b1; end
         default:  dec = '0;
      endcase
   end

   // ready is forced low while reset is asserted so fetch never hands off into a clearing stage
   assign ready  = !reset && (state_q != HALTED) && (!ctl_q.valid || !bus.stall_i);
   assign accept = bus.instr_valid_i && ready;

   always_comb begin
      ctl_d   = ctl_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = (state_q == HALTED) && DONE_LEVEL && done_q;
      if (ctl_q.valid && bus.stall_i) begin
         ctl_d = ctl_q;
      end else if (accept) begin
         if (state_q == SQUASH) begin
            ctl_d = '0;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
         end else begin
            ctl_d = dec;
            if (is_halt) begin
               state_d = HALTED;
               done_d  = 1'b1;
            end else if (is_taken) begin
               state_d = SQUASH;
               cnt_d   = 3'(FLUSH_SLOTS);
            end
         end
      end else begin
         ctl_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         ctl_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready_o              = ready;
   assign bus.valid_o              = ctl_q.valid;
   assign bus.alucontrol_o         = ctl_q.alu;
   assign bus.rs_addr_o            = ctl_q.rs;
   assign bus.rt_addr_o            = ctl_q.rt;
   assign bus.write_addr_o         = ctl_q.wa;
   assign bus.immediate_o          = ctl_q.imm;
   assign bus.regwrite_o           = ctl_q.regwrite;
   assign bus.CBwrite_o            = ctl_q.cbwrite;
   assign bus.memread_o            = ctl_q.memread;
   assign bus.memwrite_o           = ctl_q.memwrite;
   assign bus.write_data_control_o = ctl_q.wdc;
   assign bus.branchf_o            = ctl_q.branchf;
   assign bus.branchb_o            = ctl_q.branchb;
   assign bus.done_o               = done_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (squash depth 2 / held done, depth 1 / pulsed done)
// share one stimulus stream and are compared against an opcode-table reference model.
module tb_decode_stage;
   typedef struct packed {
      logic       valid;
      logic [3:0] alu;
      logic [2:0] rs;
      logic [2:0] rt;
      logic [2:0] wa;
      logic [4:0] imm;
      logic       rw;
      logic       cbw;
      logic       mr;
      logic       mw;
      logic       wdc;
      logic       bf;
      logic       bb;
   } ctl_t;

   logic       clk;
   logic       reset;
   logic       iv;
   logic [7:0] ins;
   logic       cb;
   logic       st;

   int checks = 0;
   int errors = 0;

   decode_if bus_a ();
   decode_if bus_b ();

   assign bus_a.instr_valid_i = iv;
   assign bus_a.instr_i       = ins;
   assign bus_a.cb_i          = cb;
   assign bus_a.stall_i       = st;
   assign bus_b.instr_valid_i = iv;
   assign bus_b.instr_i       = ins;
   assign bus_b.cb_i          = cb;
   assign bus_b.stall_i       = st;

   decode_stage #(.FLUSH_SLOTS(2), .DONE_LEVEL(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
   decode_stage #(.FLUSH_SLOTS(1), .DONE_LEVEL(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

   ctl_t obs [2];
   logic rdy [2];
   logic dn  [2];

   assign obs[0] = {bus_a.valid_o, bus_a.alucontrol_o, bus_a.rs_addr_o, bus_a.rt_addr_o, bus_a.write_addr_o,
                    bus_a.immediate_o, bus_a.regwrite_o, bus_a.CBwrite_o, bus_a.memread_o, bus_a.memwrite_o,
                    bus_a.write_data_control_o, bus_a.branchf_o, bus_a.branchb_o};
   assign obs[1] = {bus_b.valid_o, bus_b.alucontrol_o, bus_b.rs_addr_o, bus_b.rt_addr_o, bus_b.write_addr_o,
                    bus_b.immediate_o, bus_b.regwrite_o, bus_b.CBwrite_o, bus_b.memread_o, bus_b.memwrite_o,
                    bus_b.write_data_control_o, bus_b.branchf_o, bus_b.branchb_o};
   assign rdy[0] = bus_a.ready_o;
   assign rdy[1] = bus_b.ready_o;
   assign dn[0]  = bus_a.done_o;
   assign dn[1]  = bus_b.done_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state per instance
   ctl_t m_out    [2];
   bit   m_halted [2];
   int   m_left   [2];
   bit   m_done   [2];
   int   flush    [2] = '{2, 1};
   bit   dlev     [2] = '{1'b1, 1'b0};

   function automatic logic [7:0] en(input ctl_t c);
      return {c.valid, c.rw, c.cbw, c.mr, c.mw, c.wdc, c.bf, c.bb};
   endfunction

   function automatic ctl_t m_decode(input logic [7:0] i, input logic c_in, output bit halt, output bit taken);
      logic [4:0] op;
      logic [2:0] lo;
      ctl_t       c;
      op = i[7:3];
      lo = i[2:0];
      c = '0;
      c.valid = 1'b1;
      halt = 1'b0;
      taken = 1'b0;
      if (op < 5'd16) begin
         c.alu = (op < 5'd8) ? 4'd0 : 4'd1;
         c.wa = i[5:3]; c.rs = lo; c.rt = 3'd7; c.rw = 1'b1;
      end else if (op >= 5'd24 && op <= 5'd27) begin
         c.alu = 4'd8; c.imm = i[4:0]; c.wa = 3'd7; c.rw = 1'b1;
      end else begin
         case (op)
            5'd28, 5'd29, 5'd20: begin
               c.alu = (op == 5'd28) ? 4'd2 : (op == 5'd29) ? 4'd3 : 4'd6;
               c.wa = lo; c.rs = lo; c.rt = 3'd7; c.rw = 1'b1;
            end
            5'd31: begin c.alu = 4'd4; c.rs = 3'd2; c.rt = 3'd5; c.wa = lo; c.rw = 1'b1; end
            5'd16: begin c.alu = 4'd5; c.rs = 3'd6; c.rt = 3'd7; c.cbw = 1'b1; end
            5'd21: begin c.alu = 4'd7; c.rs = lo; c.rt = 3'd7; c.cbw = 1'b1; end
            5'd18: begin c.alu = 4'd1; c.wa = lo; c.rt = 3'd7; c.mr = 1'b1; c.wdc = 1'b1; c.rw = 1'b1; end
            5'd19: begin c.alu = 4'd1; c.rs = lo; c.rt = 3'd7; c.mw = 1'b1; end
            5'd23: begin c.alu = 4'd9; c.rs = lo; c.rt = 3'd7; c.wa = 3'd7; c.rw = 1'b1; end
            5'd30, 5'd22: begin
               c.alu = 4'd1; c.rs = lo;
               c.bf = (op == 5'd30) && c_in;
               c.bb = (op == 5'd22) && c_in;
               taken = c_in;
            end
            default: begin c.alu = 4'd1; halt = 1'b1; end
         endcase
      end
      return c;
   endfunction

   function automatic bit m_ready(input int k, input logic s);
      return !m_halted[k] && (!m_out[k].valid || !s);
   endfunction

   task automatic m_step(input int k, input logic v, input logic [7:0] i, input logic c_in, input logic s);
      bit   acc, newdone, halt, taken;
      ctl_t d;
      acc = v && m_ready(k, s);
      newdone = m_halted[k] && dlev[k] && m_done[k];
      if (m_out[k].valid && s) begin
         m_out[k] = m_out[k];
      end else if (acc) begin
         if (m_left[k] > 0) begin
            m_out[k] = '0;
            m_left[k]--;
         end else begin
            d = m_decode(i, c_in, halt, taken);
            m_out[k] = d;
            if (halt) begin
               m_halted[k] = 1'b1;
               newdone = 1'b1;
            end else if (taken) begin
               m_left[k] = flush[k];
            end
         end
      end else begin
         m_out[k] = '0;
      end
      m_done[k] = newdone;
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic check_outs();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("enables%0d", k), 32'(en(obs[k])), 32'(en(m_out[k])));
         if (m_out[k].valid) chk($sformatf("fields%0d", k), 32'(obs[k]), 32'(m_out[k]));
         chk($sformatf("done%0d", k), 32'(dn[k]), 32'(m_done[k]));
      end
   endtask

   // called at posedge+1: drive one cycle, check ready mid-cycle, check registered outputs after the edge
   task automatic cyc(input logic v, input logic [7:0] i, input logic c_in, input logic s);
      iv = v; ins = i; cb = c_in; st = s;
      #3;
      for (int k = 0; k < 2; k++) chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_ready(k, s)));
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) m_step(k, v, i, c_in, s);
      check_outs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         m_out[k] = '0; m_halted[k] = 1'b0; m_left[k] = 0; m_done[k] = 1'b0;
         chk($sformatf("rst_outs%0d", k), 32'(obs[k]), 32'd0);
         chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
         chk($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   int hcnt;

   initial begin
      reset = 1'b1; iv = 1'b0; ins = 8'h00; cb = 1'b0; st = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // reset mid-stream, then add 0x5B
      cyc(1'b1, 8'h12, 1'b0, 1'b0);
      cyc(1'b1, 8'hC7, 1'b0, 1'b0);
      do_reset();
      cyc(1'b1, 8'h5B, 1'b0, 1'b0);
      chk("t1_valid", 32'(bus_a.valid_o), 32'd1);
      chk("t1_alu", 32'(bus_a.alucontrol_o), 32'd1);
      chk("t1_wa", 32'(bus_a.write_addr_o), 32'd3);
      chk("t1_rs", 32'(bus_a.rs_addr_o), 32'd3);
      chk("t1_rt", 32'(bus_a.rt_addr_o), 32'd7);
      chk("t1_regwrite", 32'(bus_a.regwrite_o), 32'd1);

      // taken forward branch, two-slot squash on dut_a
      cyc(1'b1, 8'hF2, 1'b1, 1'b0);
      chk("t2_branchf", 32'(bus_a.branchf_o), 32'd1);
      cyc(1'b1, 8'h41, 1'b0, 1'b0);
      chk("t2_drop1", 32'(bus_a.valid_o), 32'd0);
      cyc(1'b1, 8'h42, 1'b0, 1'b0);
      chk("t2_drop2", 32'(bus_a.valid_o), 32'd0);
      cyc(1'b1, 8'h43, 1'b0, 1'b0);
      chk("t2_resume", 32'(bus_a.regwrite_o), 32'd1);

      // stall while a load is presented
      cyc(1'b1, 8'h95, 1'b0, 1'b0);
      cyc(1'b1, 8'h41, 1'b0, 1'b1);
      cyc(1'b1, 8'h41, 1'b0, 1'b1);
      chk("t3_hold_memread", 32'(bus_a.memread_o), 32'd1);
      cyc(1'b1, 8'h41, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // halt inside the squash window is dropped
      cyc(1'b1, 8'hF1, 1'b1, 1'b0);
      cyc(1'b1, 8'h88, 1'b0, 1'b0);
      chk("t5_no_done", 32'(bus_a.done_o), 32'd0);
      cyc(1'b1, 8'h42, 1'b0, 1'b0);
      cyc(1'b1, 8'h43, 1'b0, 1'b0);

      // halt: held done on dut_a, pulse on dut_b
      cyc(1'b1, 8'h88, 1'b0, 1'b0);
      chk("t4_done", 32'(bus_a.done_o), 32'd1);
      for (int n = 0; n < 10; n++) cyc(1'b1, 8'($urandom), 1'(($urandom)), 1'b0);
      chk("t4_done_held", 32'(bus_a.done_o), 32'd1);
      chk("t4_pulse_gone", 32'(bus_b.done_o), 32'd0);

      // reset while halted, then while squashing
      do_reset();
      cyc(1'b1, 8'hB6, 1'b1, 1'b0);
      do_reset();
      cyc(1'b1, 8'h5B, 1'b0, 1'b0);

      // randomized traffic
      hcnt = 0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 63) == 0 || hcnt > 4) begin
            do_reset();
            hcnt = 0;
         end else begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0));
            if (m_halted[0] && m_halted[1]) hcnt++;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
